crc32_stream_engine: RTL and testbench

CRC32_STREAM_ENGINE -- requirements
Module: crc32_stream_engine

---
 rtl/crc32_pkg.sv | 22 ++
 rtl/crc32_next.sv | 35 +++
 rtl/crc32_stream_engine.sv | 171 +++++++++++++++++
 tb/tb_crc32_stream_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// Shared definitions for the CRC-32 stream engine: polynomial default, FCS residue,
// FSM state type and a bit-reversal helper.
package crc32_pkg;

    localparam logic [31:0] CRC_POLY_DEFAULT = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE      = 32'hDEBB20E3;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } crc_state_t;

    function automatic logic [31:0] reverse32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_next.sv
// Combinational reflected CRC-32 update over the first nbytes bytes of a beat,
// byte 0 first and LSB-first within each byte.
module crc32_next
    import crc32_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter logic [31:0] CRC_POLY = CRC_POLY_DEFAULT
) (
    input  logic [31:0]                  crc,
    input  logic [DATA_W-1:0]            data,
    input  logic [$clog2(DATA_W/8+1)-1:0] nbytes,
    output logic [31:0]                  crc_next
);

    localparam int          NB       = DATA_W / 8;
    localparam int          CNT_W    = $clog2(NB + 1);
    localparam logic [31:0] POLY_REV = reverse32(CRC_POLY);

    always_comb begin
        logic [31:0] c;
        logic        fb;
        c  = crc;
        fb = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (CNT_W'(i) < nbytes) begin
                for (int b = 0; b < 8; b++) begin
                    fb = c[0] ^ data[i*8 + b];
                    c  = {1'b0, c[31:1]} ^ (fb ? POLY_REV : 32'h0);
                end
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/crc32_stream_engine.sv
// Streaming CRC-32 engine: beat register stage, LFSR stage, registered result.
// Optional FCS residue check port enabled by macro CRC32_STREAM_CHECK_EN.
module crc32_stream_engine
    import crc32_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_POLY = CRC_POLY_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_keep,
    input  logic                s_sop,
    input  logic                s_eop,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [31:0]         m_crc,
    output logic [15:0]         m_bytes,
    output logic                m_err,
`ifdef CRC32_STREAM_CHECK_EN
    output logic                m_fcs_ok,
`endif
    output crc_state_t          dbg_state
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = $clog2(NB + 1);

    crc_state_t       state;
    logic             sticky_err;
    logic             adv;
    logic [CNT_W-1:0] keep_run;
    logic [CNT_W-1:0] beat_nbytes;
    logic             keep_err;

    logic              s1_valid;
    logic              s1_sop;
    logic              s1_eop;
    logic              s1_err;
    logic [DATA_W-1:0] s1_data;
    logic [CNT_W-1:0]  s1_nbytes;

    logic [31:0] lfsr;
    logic [31:0] lfsr_base;
    logic [31:0] lfsr_next;
    logic        s2_done;
    logic        s2_err;
    logic [15:0] byte_cnt;
    logic [16:0] cnt_sum;

    // Handshakes: a beat transfers on an edge with s_valid && s_ready, a result on an
    // edge with m_valid && m_ready; a pending unaccepted result freezes the whole pipe.
    assign s_ready   = !(m_valid && !m_ready);
    assign adv       = s_ready;
    assign dbg_state = state;

    // keep_run = bytes below the lowest cleared keep bit.
    always_comb begin
        logic run_done;
        keep_run = '0;
        run_done = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (run_done || !s_keep[i]) begin
                run_done = 1'b1;
            end else begin
                keep_run = CNT_W'(i + 1);
            end
        end
        beat_nbytes = s_eop ? keep_run : CNT_W'(NB);
        keep_err    = s_eop ? ((s_keep >> keep_run) != '0) : !(&s_keep);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sticky_err <= 1'b0;
            s1_valid   <= 1'b0;
            s1_sop     <= 1'b0;
            s1_eop     <= 1'b0;
            s1_err     <= 1'b0;
            s1_data    <= '0;
            s1_nbytes  <= '0;
        end else if (adv) begin
            s1_valid <= 1'b0;
            if (s_valid) begin
                s1_data   <= s_data;
                s1_nbytes <= beat_nbytes;
                s1_sop    <= s_sop;
                s1_eop    <= s_eop;
                case (state)
                    ST_IDLE: begin
                        if (s_sop) begin
                            s1_valid   <= 1'b1;
                            s1_err     <= keep_err | sticky_err;
                            sticky_err <= 1'b0;
                            state      <= s_eop ? ST_IDLE : ST_IN_FRAME;
                        end else begin
                            sticky_err <= 1'b1;
                        end
                    end
                    ST_IN_FRAME: begin
                        // A sop here abandons the running frame and flags the new one.
                        s1_valid <= 1'b1;
                        s1_err   <= keep_err | s_sop;
                        if (s_eop) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign lfsr_base = s1_sop ? CRC_INIT : lfsr;
    assign cnt_sum   = {1'b0, (s1_sop ? 16'h0 : byte_cnt)} + 17'(s1_nbytes);

    crc32_next #(
        .DATA_W   (DATA_W),
        .CRC_POLY (CRC_POLY)
    ) u_next (
        .crc      (lfsr_base),
        .data     (s1_data),
        .nbytes   (s1_nbytes),
        .crc_next (lfsr_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr     <= CRC_INIT;
            byte_cnt <= '0;
            s2_err   <= 1'b0;
            s2_done  <= 1'b0;
        end else if (adv) begin
            s2_done <= s1_valid && s1_eop;
            if (s1_valid) begin
                lfsr     <= lfsr_next;
                byte_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
                s2_err   <= (s1_sop ? 1'b0 : s2_err) | s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid  <= 1'b0;
            m_crc    <= '0;
            m_bytes  <= '0;
            m_err    <= 1'b0;
`ifdef CRC32_STREAM_CHECK_EN
            m_fcs_ok <= 1'b0;
`endif
        end else if (adv) begin
            if (s2_done) begin
                m_valid  <= 1'b1;
                m_crc    <= ~lfsr;
                m_bytes  <= byte_cnt;
                m_err    <= s2_err;
`ifdef CRC32_STREAM_CHECK_EN
                m_fcs_ok <= (lfsr == CRC_RESIDUE);
`endif
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Directed scoreboard bench for crc32_stream_engine (DATA_W = 64); the m_fcs_ok
// checks are compiled in when CRC32_STREAM_CHECK_EN is defined.
module tb_crc32_stream_engine;
    import crc32_pkg::*;

    localparam int EXP_W = 51;  // {crc_care, fcs, err, bytes[15:0], crc[31:0]}

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic        s_sop;
    logic        s_eop;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_crc;
    logic [15:0] m_bytes;
    logic        m_err;
`ifdef CRC32_STREAM_CHECK_EN
    logic        m_fcs_ok;
`endif
    crc_state_t  dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int handshakes = 0;
    int pushes = 0;
    logic [EXP_W-1:0] exp_q[$];

    crc32_stream_engine #(.DATA_W(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_keep    (s_keep),
        .s_sop     (s_sop),
        .s_eop     (s_eop),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_crc     (m_crc),
        .m_bytes   (m_bytes),
        .m_err     (m_err),
`ifdef CRC32_STREAM_CHECK_EN
        .m_fcs_ok  (m_fcs_ok),
`endif
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_result(input logic [31:0] crc, input logic [15:0] bytes,
                                 input logic err, input logic fcs, input logic crc_care);
        exp_q.push_back({crc_care, fcs, err, bytes, crc});
        pushes++;
    endtask

    // Driver: present one beat and return after the edge that accepts it.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic sop,
                             input logic eop, output int acc_cyc);
        int guard;
        guard = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_sop   = sop;
        s_eop   = eop;
        while (!s_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL s_ready_timeout: s_ready 0 after %0d cycles, required 1", guard);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic sop, input logic eop);
        int unused_cyc;
        send_beat(d, k, sop, eop, unused_cyc);
    endtask

    task automatic send_str(input string s);
        int n;
        int nbeats;
        logic [63:0] d;
        logic [7:0]  k;
        n = s.len();
        nbeats = (n == 0) ? 1 : (n + 7) / 8;
        for (int b = 0; b < nbeats; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++) begin
                if (b * 8 + j < n) begin
                    d[j*8 +: 8] = s[b*8 + j];
                    k[j] = 1'b1;
                end
            end
            beat(d, k, b == 0, b == nbeats - 1);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (reset_n && m_valid && m_ready) begin
            handshakes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got crc %h bytes %0d, required no result", m_crc, m_bytes);
            end else begin
                e = exp_q.pop_front();
                if (e[50]) check("m_crc", m_crc, e[31:0]);
                check("m_bytes", 32'(m_bytes), 32'(e[47:32]));
                check("m_err", 32'(m_err), 32'(e[48]));
`ifdef CRC32_STREAM_CHECK_EN
                check("m_fcs_ok", 32'(m_fcs_ok), 32'(e[49]));
`endif
            end
        end
    end

    initial begin
        int acc;
        int lat;
        int hs0;
        s_valid = 1'b0;
        s_data  = '0;
        s_keep  = '0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        m_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_crc", m_crc, 32'h0);
        check("rst_m_bytes", 32'(m_bytes), 32'd0);
        check("rst_m_err", 32'(m_err), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Check value "123456789" in two beats, with latency measurement
        expect_result(32'hCBF43926, 16'd9, 1'b0, 1'b0, 1'b1);
        beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
        send_beat(64'h0000000000000039, 8'h01, 1'b0, 1'b1, acc);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        check("eop_to_valid_latency", lat, 32'd2);
        drain();

        // Same frame with the result held back for 5 cycles
        m_ready = 1'b0;
        hs0 = handshakes;
        expect_result(32'hCBF43926, 16'd9, 1'b0, 1'b0, 1'b1);
        beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
        beat(64'h0000000000000039, 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_s_ready", 32'(s_ready), 32'd0);
            check("stall_m_valid", 32'(m_valid), 32'd1);
            check("stall_m_crc", m_crc, 32'hCBF43926);
            check("stall_m_bytes", 32'(m_bytes), 32'd9);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();
        check("stall_handshakes", handshakes - hs0, 32'd1);

        // Back-to-back frames of various lengths
        expect_result(32'hE8B7BE43, 16'd1, 1'b0, 1'b0, 1'b1);
        expect_result(32'h352441C2, 16'd3, 1'b0, 1'b0, 1'b1);
        expect_result(32'h414FA339, 16'd43, 1'b0, 1'b0, 1'b1);
        expect_result(32'hCBF43926, 16'd9, 1'b0, 1'b0, 1'b1);
        send_str("a");
        send_str("abc");
        send_str("The quick brown fox jumps over the lazy dog");
        send_str("123456789");
        drain();

        // sop inside a frame restarts it and flags the restarted frame
        expect_result(32'hCBF43926, 16'd9, 1'b1, 1'b0, 1'b1);
        beat(64'h4141414141414141, 8'hFF, 1'b1, 1'b0);
        beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
        beat(64'h0000000000000039, 8'h01, 1'b0, 1'b1);
        drain();

        // Beat without sop in IDLE is dropped; error lands on the next result only
        beat(64'h1111111111111111, 8'hFF, 1'b0, 1'b1);
        expect_result(32'hCBF43926, 16'd9, 1'b1, 1'b0, 1'b1);
        expect_result(32'h352441C2, 16'd3, 1'b0, 1'b0, 1'b1);
        send_str("123456789");
        send_str("abc");
        drain();

        // Non-contiguous keep on eop: only byte 0 counts
        expect_result(32'hCBF43926, 16'd9, 1'b1, 1'b0, 1'b1);
        beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
        beat(64'h0000000000770039, 8'h05, 1'b0, 1'b1);
        // Partial keep on a non-eop beat: all 8 bytes still processed
        expect_result(32'hCBF43926, 16'd9, 1'b1, 1'b0, 1'b1);
        beat(64'h3837363534333231, 8'h0F, 1'b1, 1'b0);
        beat(64'h0000000000000039, 8'h01, 1'b0, 1'b1);
        // Empty frame
        expect_result(32'h00000000, 16'd0, 1'b0, 1'b0, 1'b1);
        beat(64'hDEADBEEFCAFEF00D, 8'h00, 1'b1, 1'b1);
        drain();

        // Frame with correct trailing FCS, then with one data bit flipped
        expect_result(32'h2144DF1C, 16'd13, 1'b0, 1'b1, 1'b1);
        beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
        beat(64'h000000CBF4392639, 8'h1F, 1'b0, 1'b1);
        expect_result(32'h0, 16'd13, 1'b0, 1'b0, 1'b0);
        beat(64'h3837363434333231, 8'hFF, 1'b1, 1'b0);
        beat(64'h000000CBF4392639, 8'h1F, 1'b0, 1'b1);
        drain();

        // Reset with a completed frame still in the pipe: no result for it
        beat(64'h3837363534333231, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        check("mid_state", 32'(dbg_state), 32'(ST_IN_FRAME));
        @(posedge clk);
        #1;
        beat(64'h0000000000000039, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("mid_rst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        expect_result(32'hCBF43926, 16'd9, 1'b0, 1'b0, 1'b1);
        send_str("123456789");
        drain();

        // Byte count saturation: 8193 full beats = 65544 bytes
        expect_result(32'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8193; i++) begin
            beat(64'h0, 8'hFF, i == 0, i == 8192);
        end
        drain();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("handshake_count", handshakes, pushes);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
